// File: rtl/sprite_line_scheduler.sv
// rtl/sprite_line_scheduler.sv - per-scanline sprite scan/fetch engine filling a ping-pong line buffer
module sprite_line_scheduler #(
    parameter int NUM_SPR     = 8,
    parameter int ROM_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 line_start,
    input  logic [7:0]           next_line,
    input  logic [NUM_SPR*8-1:0] spr_x,
    input  logic [NUM_SPR*8-1:0] spr_y,
    input  logic [NUM_SPR*6-1:0] spr_num,
    input  logic [NUM_SPR-1:0]   spr_xflip,
    input  logic [NUM_SPR-1:0]   spr_yflip,
    output logic [11:0]          rom_addr,
    input  logic [7:0]           rom_data,
    input  logic                 disp_rd,
    input  logic [7:0]           disp_x,
    output logic                 disp_hit,
    output logic [1:0]           disp_data,
    output logic [2:0]           disp_id,
    output logic                 busy,
    output logic                 overrun
);

    localparam int IW = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EVAL,
        S_FETCH,
        S_WAIT,
        S_WRITE
    } state_t;

    state_t        state;
    logic          front;
    logic [255:0]  valid [2];
    logic [4:0]    bank [0:511];
    logic [7:0]    line_q;
    logic [IW-1:0] idx;
    logic [1:0]    byte_b;
    logic [1:0]    pix_o;
    logic [1:0]    wait_cnt;
    logic [3:0]    row_q;
    logic [7:0]    data_q;

    logic [7:0]    cur_x;
    logic [7:0]    cur_y;
    logic [5:0]    cur_num;
    logic          cur_xf;
    logic          cur_yf;
    logic          hit;
    logic [3:0]    row_raw;
    logic [3:0]    row_eval;
    logic [7:0]    pix_byte;
    logic [1:0]    code;
    logic [3:0]    src_col;
    logic [3:0]    dst_off;
    logic [8:0]    dst;
    logic          do_write;
    logic          back;
    logic          fn;
    logic [4:0]    rd_entry;
    logic [2:0]    write_id;

    always_comb begin
        cur_x    = spr_x[int'(idx)*8 +: 8];
        cur_y    = spr_y[int'(idx)*8 +: 8];
        cur_num  = spr_num[int'(idx)*6 +: 6];
        cur_xf   = spr_xflip[idx];
        cur_yf   = spr_yflip[idx];
        // 9-bit compare so a sprite near the bottom never wraps to the top rows
        hit      = ({1'b0, line_q} >= {1'b0, cur_y}) &&
                   ({1'b0, line_q} <  ({1'b0, cur_y} + 9'd16));
        row_raw  = line_q[3:0] - cur_y[3:0];
        row_eval = cur_yf ? ~row_raw : row_raw;
        pix_byte = (pix_o == 2'd0) ? rom_data : data_q;
        code     = pix_byte[{pix_o, 1'b0} +: 2];
        src_col  = {byte_b, pix_o};
        dst_off  = cur_xf ? ~src_col : src_col;
        dst      = {1'b0, cur_x} + {5'b0, dst_off};
        do_write = (state == S_WRITE) && !line_start && (code != 2'd0) && !dst[8];
        back     = ~front;
        fn       = line_start ? ~front : front;
        rd_entry = bank[{fn, disp_x}];
        write_id = 3'(idx);
    end

    // Pixel storage is plain RAM; the valid vectors alone define what is visible.
    always_ff @(posedge clk) begin
        if (do_write) begin
            bank[{back, dst[7:0]}] <= {code, write_id};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            front     <= 1'b0;
            valid[0]  <= '0;
            valid[1]  <= '0;
            line_q    <= '0;
            idx       <= '0;
            byte_b    <= '0;
            pix_o     <= '0;
            wait_cnt  <= '0;
            row_q     <= '0;
            data_q    <= '0;
            rom_addr  <= '0;
            disp_hit  <= 1'b0;
            disp_data <= '0;
            disp_id   <= '0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            overrun <= line_start && (state != S_IDLE);

            if (disp_rd) begin
                disp_hit  <= valid[fn][disp_x];
                disp_data <= valid[fn][disp_x] ? rd_entry[4:3] : 2'd0;
                disp_id   <= valid[fn][disp_x] ? rd_entry[2:0] : 3'd0;
            end

            if (do_write) begin
                valid[back][dst[7:0]] <= 1'b1;
            end

            if (line_start) begin
                // Swap banks; the bank becoming back starts empty, any fill in flight is dropped.
                front        <= ~front;
                valid[front] <= '0;
                line_q       <= next_line;
                idx          <= IW'(NUM_SPR - 1);
                state        <= S_EVAL;
                busy         <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        busy <= 1'b0;
                    end
                    S_EVAL: begin
                        if (hit) begin
                            row_q  <= row_eval;
                            byte_b <= 2'd0;
                            state  <= S_FETCH;
                        end else if (idx == '0) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            idx <= idx - 1'b1;
                        end
                    end
                    S_FETCH: begin
                        rom_addr <= {cur_num, row_q, byte_b};
                        wait_cnt <= 2'(ROM_LATENCY - 1);
                        state    <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (wait_cnt == 2'd0) begin
                            pix_o <= 2'd0;
                            state <= S_WRITE;
                        end else begin
                            wait_cnt <= wait_cnt - 1'b1;
                        end
                    end
                    S_WRITE: begin
                        // rom_data is live only in the first write cycle; keep it for the rest
                        if (pix_o == 2'd0) begin
                            data_q <= rom_data;
                        end
                        pix_o <= pix_o + 1'b1;
                        if (pix_o == 2'd3) begin
                            if (byte_b != 2'd3) begin
                                byte_b <= byte_b + 1'b1;
                                state  <= S_FETCH;
                            end else if (idx == '0) begin
                                state <= S_IDLE;
                                busy  <= 1'b0;
                            end else begin
                                idx   <= idx - 1'b1;
                                state <= S_EVAL;
                            end
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// tb/tb_sprite_line_scheduler.sv - directed table-driven bench for sprite_line_scheduler
module tb_sprite_line_scheduler;

    localparam int N = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         line_start;
    logic [7:0]   next_line;
    logic         disp_rd;
    logic [7:0]   disp_x;
    logic [7:0]   sx [N];
    logic [7:0]   sy [N];
    logic [5:0]   sn [N];
    logic [N-1:0] sxf;
    logic [N-1:0] syf;
    logic [N*8-1:0] spr_x;
    logic [N*8-1:0] spr_y;
    logic [N*6-1:0] spr_num;

    logic [11:0] rom_addr, rom_addr2;
    logic [7:0]  rom_data, rom_data2, rp2a;
    logic        disp_hit, disp_hit2;
    logic [1:0]  disp_data, disp_data2;
    logic [2:0]  disp_id, disp_id2;
    logic        busy, busy2, overrun, overrun2;

    always_comb begin
        spr_x   = '0;
        spr_y   = '0;
        spr_num = '0;
        for (int i = 0; i < N; i++) begin
            spr_x[i*8 +: 8]   = sx[i];
            spr_y[i*8 +: 8]   = sy[i];
            spr_num[i*6 +: 6] = sn[i];
        end
    end

    sprite_line_scheduler #(.NUM_SPR(N), .ROM_LATENCY(1)) dut (
        .clk(clk), .rst(rst), .line_start(line_start), .next_line(next_line),
        .spr_x(spr_x), .spr_y(spr_y), .spr_num(spr_num),
        .spr_xflip(sxf), .spr_yflip(syf),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .disp_rd(disp_rd), .disp_x(disp_x),
        .disp_hit(disp_hit), .disp_data(disp_data), .disp_id(disp_id),
        .busy(busy), .overrun(overrun)
    );

    sprite_line_scheduler #(.NUM_SPR(N), .ROM_LATENCY(2)) dut2 (
        .clk(clk), .rst(rst), .line_start(line_start), .next_line(next_line),
        .spr_x(spr_x), .spr_y(spr_y), .spr_num(spr_num),
        .spr_xflip(sxf), .spr_yflip(syf),
        .rom_addr(rom_addr2), .rom_data(rom_data2),
        .disp_rd(disp_rd), .disp_x(disp_x),
        .disp_hit(disp_hit2), .disp_data(disp_data2), .disp_id(disp_id2),
        .busy(busy2), .overrun(overrun2)
    );

    function automatic logic [7:0] rom_f(input logic [11:0] a);
        return 8'(a[7:0] * 8'd29) ^ {2'b00, a[11:6]} ^ 8'hA6;
    endfunction

    // Synchronous ROMs: one and two register stages
    always @(posedge clk) begin
        rom_data  <= rom_f(rom_addr);
        rp2a      <= rom_f(rom_addr2);
        rom_data2 <= rp2a;
    end

    // Per-column reference: first opaque sprite in index order wins
    function automatic logic [5:0] model(input logic [7:0] col, input logic [7:0] line);
        logic [5:0] res;
        logic       found;
        logic [3:0] r;
        logic [3:0] s;
        logic [7:0] b;
        logic [1:0] code;
        res   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && ({1'b0, line} >= {1'b0, sy[i]}) && ({1'b0, line} < {1'b0, sy[i]} + 9'd16) &&
                ({1'b0, col} >= {1'b0, sx[i]}) && ({1'b0, col} < {1'b0, sx[i]} + 9'd16)) begin
                r = 4'(line - sy[i]);
                if (syf[i]) r = 4'd15 - r;
                s = 4'(col - sx[i]);
                if (sxf[i]) s = 4'd15 - s;
                b = rom_f({sn[i], r, s[3:2]});
                code = b[int'(s[1:0])*2 +: 2];
                if (code != 2'd0) begin
                    res   = {1'b1, code, 3'(i)};
                    found = 1'b1;
                end
            end
        end
        return res;
    endfunction

    int pass_cnt = 0;
    int total    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; line_start = 1'b0; disp_rd = 1'b0; disp_x = '0; next_line = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_default();
        for (int i = 0; i < N; i++) begin
            sx[i] = '0; sy[i] = 8'd200; sn[i] = '0;
        end
        sxf = '0; syf = '0;
    endtask

    task automatic pulse_line(input logic [7:0] ln);
        @(negedge clk);
        next_line = ln; line_start = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
    endtask

    task automatic measure(output int c1, output int c2, output int ov1, output int ov2,
                           output logic [11:0] a1, output logic [11:0] a2);
        int guard;
        c1 = 0; c2 = 0; ov1 = 0; ov2 = 0; a1 = '0; a2 = '0; guard = 0;
        while ((busy || busy2) && guard < 3000) begin
            if (busy) c1++;
            if (busy2) c2++;
            if (overrun) ov1++;
            if (overrun2) ov2++;
            if (a1 == 12'd0) a1 = rom_addr;
            if (a2 == 12'd0) a2 = rom_addr2;
            @(negedge clk);
            guard++;
        end
        chk("fill_timeout", (guard < 3000) ? 1 : 0, 1);
    endtask

    task automatic read_col(input string name, input logic [7:0] c, input logic [7:0] line);
        disp_rd = 1'b1; disp_x = c;
        @(negedge clk);
        disp_rd = 1'b0;
        chk(name, {disp_hit, disp_data, disp_id}, model(c, line));
        chk({name, "_l2"}, {disp_hit2, disp_data2, disp_id2}, model(c, line));
    endtask

    typedef struct {
        int          ia;
        logic [7:0]  xa, ya;
        logic [5:0]  na;
        logic        xfa, yfa;
        logic        en_b;
        int          ib;
        logic [7:0]  xb, yb;
        logic [5:0]  nb;
        logic [7:0]  line;
        logic [11:0] addr0;
        int          hits;
    } vec_t;

    vec_t vt [7];

    initial begin
        int c1, c2, ov1, ov2;
        logic [11:0] a1, a2;
        rst = 1'b1; line_start = 1'b0; disp_rd = 1'b0; disp_x = '0; next_line = '0;
        set_default();

        //          ia  xa     ya     na  xf yf  enb ib  xb     yb     nb  line    addr0    hits
        vt[0] = '{3, 8'd40, 8'd100, 6'd5,  0, 0, 0, 0, 8'd0,  8'd0,  6'd0, 8'd105, 12'h154, 1};
        vt[1] = '{3, 8'd40, 8'd100, 6'd5,  1, 0, 0, 0, 8'd0,  8'd0,  6'd0, 8'd105, 12'h154, 1};
        vt[2] = '{3, 8'd40, 8'd100, 6'd5,  0, 1, 0, 0, 8'd0,  8'd0,  6'd0, 8'd105, 12'h168, 1};
        vt[3] = '{5, 8'd60, 8'd10,  6'd2,  0, 0, 1, 0, 8'd60, 8'd10, 6'd1, 8'd12,  12'h088, 2};
        vt[4] = '{2, 8'd250, 8'd0,  6'd7,  0, 0, 0, 0, 8'd0,  8'd0,  6'd0, 8'd3,   12'h1CC, 1};
        vt[5] = '{1, 8'd30, 8'd250, 6'd9,  0, 0, 0, 0, 8'd0,  8'd0,  6'd0, 8'd4,   12'h000, 0};
        vt[6] = '{6, 8'd0,  8'd250, 6'd63, 0, 0, 0, 0, 8'd0,  8'd0,  6'd0, 8'd255, 12'hFD4, 1};

        for (int k = 0; k < 7; k++) begin
            do_reset();
            chk("rst_busy", busy, 0);
            chk("rst_overrun", overrun, 0);
            chk("rst_rom_addr", rom_addr, 0);
            chk("rst_disp", {disp_hit, disp_data, disp_id}, 0);
            set_default();
            sx[vt[k].ia] = vt[k].xa; sy[vt[k].ia] = vt[k].ya; sn[vt[k].ia] = vt[k].na;
            sxf[vt[k].ia] = vt[k].xfa; syf[vt[k].ia] = vt[k].yfa;
            if (vt[k].en_b) begin
                sx[vt[k].ib] = vt[k].xb; sy[vt[k].ib] = vt[k].yb; sn[vt[k].ib] = vt[k].nb;
            end
            pulse_line(vt[k].line);
            measure(c1, c2, ov1, ov2, a1, a2);
            chk("fill_cycles", c1, 8 + vt[k].hits * 24);
            chk("fill_cycles_l2", c2, 8 + vt[k].hits * 28);
            chk("first_rom_addr", a1, vt[k].addr0);
            chk("first_rom_addr_l2", a2, vt[k].addr0);
            chk("no_overrun", ov1 + ov2, 0);
            // Read issued together with line_start must see the freshly swapped bank
            @(negedge clk);
            next_line = vt[k].line; line_start = 1'b1; disp_rd = 1'b1; disp_x = vt[k].xa;
            @(negedge clk);
            line_start = 1'b0; disp_rd = 1'b0;
            chk("swap_read", {disp_hit, disp_data, disp_id}, model(vt[k].xa, vt[k].line));
            chk("swap_read_l2", {disp_hit2, disp_data2, disp_id2}, model(vt[k].xa, vt[k].line));
            @(negedge clk);
            chk("read_hold", {disp_hit, disp_data, disp_id}, model(vt[k].xa, vt[k].line));
            for (int c = 0; c < 256; c++) read_col("line_col", 8'(c), vt[k].line);
        end

        // All eight sprites on one line, then an overrun restart
        do_reset();
        set_default();
        for (int i = 0; i < N; i++) begin
            sx[i] = 8'(20 * i); sy[i] = 8'd10; sn[i] = 6'(i + 8);
        end
        sxf = 8'b1010_0101; syf = 8'b0110_0110;
        pulse_line(8'd12);
        measure(c1, c2, ov1, ov2, a1, a2);
        chk("full_cycles", c1, 200);
        chk("full_cycles_l2", c2, 232);
        pulse_line(8'd12);
        repeat (44) @(negedge clk);
        chk("busy_before_overrun", {busy, busy2}, 2'b11);
        pulse_line(8'd12);
        chk("overrun_pulse", {overrun, overrun2}, 2'b11);
        measure(c1, c2, ov1, ov2, a1, a2);
        chk("overrun_width", ov1, 1);
        chk("overrun_width_l2", ov2, 1);
        chk("restart_cycles", c1, 200);
        chk("restart_cycles_l2", c2, 232);
        chk("overrun_clear", {overrun, overrun2}, 2'b00);
        disp_rd = 1'b1; disp_x = 8'd0;
        @(negedge clk);
        disp_rd = 1'b0;
        chk("partial_col0", {disp_hit, disp_data, disp_id}, 0);
        chk("partial_col0_l2", {disp_hit2, disp_data2, disp_id2}, 0);
        for (int c = 140; c < 156; c++) read_col("partial_spr7", 8'(c), 8'd12);
        pulse_line(8'd12);
        for (int c = 0; c < 256; c++) read_col("full_col", 8'(c), 8'd12);

        // Reset in the middle of sprite 3's first write burst
        do_reset();
        set_default();
        sx[3] = 8'd40; sy[3] = 8'd100; sn[3] = 6'd5;
        pulse_line(8'd105);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_outputs", {busy, overrun, rom_addr, disp_hit, disp_data, disp_id}, 0);
        chk("midrst_outputs_l2", {busy2, overrun2, rom_addr2, disp_hit2, disp_data2, disp_id2}, 0);
        rst = 1'b0;
        disp_rd = 1'b1; disp_x = 8'd40;
        @(negedge clk);
        disp_rd = 1'b0;
        chk("midrst_read", {disp_hit, disp_data, disp_id}, 0);
        next_line = 8'd105; line_start = 1'b1; disp_rd = 1'b1; disp_x = 8'd44;
        @(negedge clk);
        line_start = 1'b0; disp_rd = 1'b0;
        chk("midrst_swap_read", {disp_hit, disp_data, disp_id}, 0);
        chk("midrst_swap_read_l2", {disp_hit2, disp_data2, disp_id2}, 0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
